// File: rtl/tdp_burst_rd_if.sv
// ---------------------------------------------------------------------------
// dti : generic valid/ready data-transfer interface.
//
// A transfer occurs on a rising clock edge where valid && ready are both high.
// The producer holds valid and data stable until the transfer completes.
//
// Parameters:
//   W  payload width
//
// Signals:
//   valid  producer -> consumer  payload is available
//   ready  consumer -> producer  consumer can accept the payload
//   data   producer -> consumer  payload, W bits
//
// Modports:
//   producer  drives valid/data, observes ready
//   consumer  observes valid/data, drives ready
// ---------------------------------------------------------------------------
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/tdp_burst_rd.sv
// ---------------------------------------------------------------------------
// tdp_burst_rd : burst read front-end for one port of the true dual-port RAM.
//
// Accepts a burst command {len, addr}, issues len+1 single-word read requests
// on consecutive addresses, and re-emits the returned read data with an
// end-of-transaction flag on the last word of each burst. A small FIFO of
// 1-bit "last" tags tracks outstanding reads so eot lines up with the data.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   cmd_if   dti.consumer  {len, addr}            burst command, addr in LSBs
//   req_if   dti.producer  {ctrl, data, addr}     RAM request (ctrl=0 read)
//   rd_if    dti.consumer  data                   read data from the RAM port
//   dout_if  dti.producer  {eot, data}            read data with end flag
//
// Optional build macro:
//   TDP_BURST_DEPTH_WRAP_EN  when defined, the burst address wraps from
//                            DEPTH-1 to 0 (non-power-of-two RAMs). When
//                            undefined, it wraps modulo 2^W_ADDR and DEPTH
//                            is unused.
// ---------------------------------------------------------------------------
module tdp_burst_rd #(
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 16,
  parameter int W_LEN     = 8,
  parameter int DEPTH     = 1024,
  parameter int TAG_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  cmd_if,
  dti.producer  req_if,
  dti.consumer  rd_if,
  dti.producer  dout_if
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [W_ADDR-1:0] cur_addr_reg, cur_addr_next, addr_inc;
  logic [W_LEN-1:0]  remaining_reg, remaining_next;

  logic last_word;
  logic req_valid, req_fire;
  logic cmd_ready, cmd_fire;
  logic dout_fire, tag_push, tag_pop;

  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             tag_full_reg, tag_empty_reg;
  logic             tag_head;

  // ---------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------
  assign last_word = (remaining_reg == '0);
  assign req_valid = (state_reg == ST_ISSUE) && !tag_full_reg;
  assign req_fire  = req_valid && req_if.ready;

  // In ISSUE a new command is taken only on the cycle the final request of
  // the current burst goes out, so bursts chain with no idle cycle.
  assign cmd_ready = (state_reg == ST_IDLE) || (req_fire && last_word);
  assign cmd_fire  = cmd_if.valid && cmd_ready;

  assign cmd_if.ready = cmd_ready;
  assign req_if.valid = req_valid;
  assign req_if.data  = {1'b0, {W_DATA{1'b0}}, cur_addr_reg};

`ifdef TDP_BURST_DEPTH_WRAP_EN
  assign addr_inc = (cur_addr_reg == W_ADDR'(DEPTH - 1)) ? '0
                                                         : cur_addr_reg + W_ADDR'(1);
`else
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);
  assign addr_inc     = cur_addr_reg + W_ADDR'(1);
`endif

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    if (cmd_fire) begin
      state_next     = ST_ISSUE;
      cur_addr_next  = cmd_if.data[W_ADDR-1:0];
      remaining_next = cmd_if.data[W_ADDR +: W_LEN];
    end else if (req_fire) begin
      if (last_word) begin
        state_next = ST_IDLE;
      end else begin
        cur_addr_next  = addr_inc;
        remaining_next = remaining_reg - W_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
    end
  end

  // ---------------------------------------------------------------------
  // Tag FIFO: one "last word" bit per outstanding read
  // ---------------------------------------------------------------------
  assign dout_fire = rd_if.valid && dout_if.ready;
  assign tag_push  = req_fire;
  // Data arriving with no tag is a protocol error; never underflow on it.
  assign tag_pop   = dout_fire && !tag_empty_reg;
  assign tag_head  = tag_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (tag_push && !tag_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!tag_push && tag_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[wr_ptr_reg] <= last_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      tag_full_reg  <= 1'b0;
      tag_empty_reg <= 1'b1;
    end else begin
      if (tag_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (tag_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      count_reg     <= count_next;
      tag_full_reg  <= (count_next == CNT_W'(TAG_DEPTH));
      tag_empty_reg <= (count_next == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Response path: straight passthrough with the tag appended as eot
  // ---------------------------------------------------------------------
  assign dout_if.valid = rd_if.valid;
  assign rd_if.ready   = dout_if.ready;
  assign dout_if.data  = {tag_head && !tag_empty_reg, rd_if.data};

`ifndef SYNTHESIS
  a_rd_without_tag : assert property (@(posedge clk) disable iff (rst)
    rd_if.valid |-> !tag_empty_reg);
`ifdef TDP_BURST_DEPTH_WRAP_EN
  a_cmd_addr_range : assert property (@(posedge clk) disable iff (rst)
    cmd_if.valid |-> (int'(cmd_if.data[W_ADDR-1:0]) < DEPTH));
`endif
`endif

endmodule

// File: doc/tdp_burst_rd.md
Name: tdp_burst_rd

Overview:
- Burst read front-end for one port of the true dual-port RAM block.
- Accepts a burst command (start address, word count) and issues a stream of single-word read requests on the RAM port's request interface.
- Consumes the port's read-data stream and re-emits it with an end-of-transaction (eot) flag on the last word of each burst.
- Sits between a DMA/consumer stage and one port of the RAM (upstream on req, downstream on dout).

Parameters:
- W_DATA, 16, RAM data width
- W_ADDR, 16, RAM address width
- W_LEN, 8, burst length field width; burst = len+1 words
- DEPTH, 1024, RAM depth; used only for address wrap when the optional feature is enabled
- TAG_DEPTH, 2, outstanding-read tag FIFO depth; minimum 2

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cmd_if  dti.consumer  W_LEN+W_ADDR  burst command {len, addr}, addr in LSBs
- req_if  dti.producer  1+W_DATA+W_ADDR  RAM request {ctrl, data, addr}, addr in LSBs
- rd_if  dti.consumer  W_DATA  read data returned by the RAM port
- dout_if  dti.producer  1+W_DATA  output {eot, data}, data in LSBs

Behaviour:
- Reset: asynchronous, active-high; clk and rst are the only clock and reset. While rst is high and after release:
  - state = IDLE
  - cmd_if.ready = 1
  - req_if.valid = 0
  - tag FIFO empty
  - dout_if.valid follows rd_if.valid, which the port holds low.
- Handshake: transfer when valid && ready on the same rising edge. A producer holds valid and data stable until transfer; this block never drops an asserted valid.
- State machine, two states:
  - IDLE: cmd_if.ready = 1, req_if.valid = 0. On cmd handshake: cur_addr <= cmd.addr, remaining <= cmd.len, go to ISSUE.
  - ISSUE: req_if.valid = !tag_full.
    - req fields: ctrl = 0 (read), data = 0, addr = cur_addr.
    - On req handshake: push tag last = (remaining == 0). If remaining != 0: cur_addr += 1, remaining -= 1.
    - On a handshake with remaining == 0: go to IDLE, unless a cmd is accepted in the same cycle.
- Back-to-back: in ISSUE, cmd_if.ready = req handshake && remaining == 0 (combinational). A cmd accepted there loads the new addr/len and stays in ISSUE. There are no bubble cycles between bursts.
- Latency: cmd handshake to first req valid is 1 cycle.
- Tag FIFO:
  - TAG_DEPTH entries of 1 bit, registered full/empty flags.
  - Push on req handshake, pop on dout handshake. Simultaneous push and pop keeps the count unchanged.
- Response path is combinational passthrough:
  - dout_if.valid = rd_if.valid
  - rd_if.ready = dout_if.ready
  - dout_if.data = {tag_head, rd_if.data}
- Address arithmetic: cur_addr + 1 wraps modulo 2^W_ADDR, e.g. 0xFFFF -> 0x0000 at default width. The optional feature changes this.
- Len: len = 0 gives a 1-word burst with eot on it; len = 2^W_LEN-1 gives 2^W_LEN words.
- Ordering: responses return in request order; tags align 1:1 with data.
- Error: rd_if.valid with the tag FIFO empty is a protocol violation. A simulation-only assertion flags it; RTL outputs eot = 0.
- Reset mid-burst: all state clears asynchronously; the remaining words of that burst are never issued.

Optional Feature:
- Macro: TDP_BURST_DEPTH_WRAP_EN.
- Defined: cur_addr wraps to 0 after DEPTH-1 (cur_addr == DEPTH-1 -> 0), for non-power-of-two RAMs.
- Command addr >= DEPTH is a protocol violation; a simulation assertion flags it.
- Undefined: wrap is modulo 2^W_ADDR only, and DEPTH is unused.

Test Plan:
- Single burst: cmd {len=3, addr=0x10}, req/dout always ready, RAM preloaded mem[a]=a+0x100 -> reqs at addrs 0x10..0x13, ctrl=0; dout 0x110..0x113 with eot=1 only on 0x113.
- Back-to-back: cmd {0,0x20} then {1,0x40} both valid from cycle 0 -> req stream 0x20,0x40,0x41 on consecutive cycles; eot on the data from 0x20 and 0x41.
- Backpressure: dout_if.ready low 5 cycles mid-burst of len=7 -> req stalls once the tag FIFO is full (≤2 outstanding); no data lost, no duplicates, 8 words total, eot on the 8th.
- Wrap: cmd {len=2, addr=0xFFFF} -> addrs 0xFFFF,0x0000,0x0001. With TDP_BURST_DEPTH_WRAP_EN, DEPTH=1000, addr=999 -> 999,0,1.
- Reset mid-burst: assert rst asynchronously after 2 of 6 reqs -> req_if.valid=0 and cmd_if.ready=1 immediately. A new cmd {0,0x5} after release returns one word with eot=1.
- Max length: W_LEN=4, len=15 -> exactly 16 reqs, eot on the 16th response only.
